// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video capture block:
//   - CNT_W_DEF     : default width of the pixel/line counters and size inputs
//   - cap_state_e   : capture FSM state encoding
//   - rgb888_to_565 : packs a {R,G,B} 8:8:8 pixel into 5:6:5 by keeping MSBs
// ---------------------------------------------------------------------------
package video_pkg;

   localparam int CNT_W_DEF = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_ACTIVE  = 2'd2
   } cap_state_e;

   // Truncation, not rounding: the frame buffer only stores the top bits.
   function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

endpackage

// File: rtl/video_capture_if.sv
// ---------------------------------------------------------------------------
// video_capture_if
// Frame-buffer write side of the capture block.
//   wr_load    : one-cycle pulse at frame start (write-address reset)
//   wr_en      : write strobe, one pixel per asserted cycle
//   wr_data    : RGB565 pixel, valid with wr_en
//   pixel_xpos : column of the pixel on wr_data
//   pixel_ypos : line of the pixel on wr_data
//   frame_done : one-cycle pulse when a frame completes
//   frame_err  : sticky size-mismatch flag, cleared by wr_load
// Modports: master = capture block (drives), slave = frame buffer (observes).
// ---------------------------------------------------------------------------
interface video_capture_if #(
   parameter int CNT_W = video_pkg::CNT_W_DEF
);

   logic             wr_load;
   logic             wr_en;
   logic [15:0]      wr_data;
   logic [CNT_W-1:0] pixel_xpos;
   logic [CNT_W-1:0] pixel_ypos;
   logic             frame_done;
   logic             frame_err;

   modport master (
      output wr_load, wr_en, wr_data, pixel_xpos, pixel_ypos, frame_done, frame_err
   );

   modport slave (
      input  wr_load, wr_en, wr_data, pixel_xpos, pixel_ypos, frame_done, frame_err
   );

endinterface

// File: rtl/vid_edge_det.sv
// ---------------------------------------------------------------------------
// vid_edge_det
// Registers an incoming level once and produces single-cycle rise/fall pulses
// from the registered copy, so all edge decisions are taken on synchronous data.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   din   : raw input level
//   level : registered copy of din
//   rise  : one-cycle pulse when level goes 0 -> 1
//   fall  : one-cycle pulse when level goes 1 -> 0
// ---------------------------------------------------------------------------
module vid_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic level_q, level_d;
   logic prev_q, prev_d;

   // prev holds the registered level one cycle older, giving the edge reference.
   always_comb begin
      level_d = din;
      prev_d  = level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         prev_q  <= prev_d;
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;
   assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/video_capture.sv
// ---------------------------------------------------------------------------
// video_capture
// Captures a DE-framed RGB888 video stream into frame-buffer write strobes
// (RGB565 plus x/y coordinates), cropping to h_disp x v_disp and flagging
// frames whose size does not match.
//   pixel_clk  : sole clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   cap_en     : capture enable (level); low returns to IDLE on the next cycle
//   vin_vs     : vertical sync, active level set by VS_POL
//   vin_de     : data enable
//   vin_rgb    : {R,G,B} 8:8:8 pixel
//   h_disp     : expected active pixels per line
//   v_disp     : expected active lines per frame
//   wr_if      : frame-buffer write side (see video_capture_if)
// Latency: a pixel at the input port appears on wr_data two clocks later
// (one input register, one output register).
// ---------------------------------------------------------------------------
module video_capture
   import video_pkg::*;
#(
   parameter bit VS_POL = 1'b1,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                  pixel_clk,
   input  logic                  sys_rst_n,
   input  logic                  cap_en,
   input  logic                  vin_vs,
   input  logic                  vin_de,
   input  logic [23:0]           vin_rgb,
   input  logic [CNT_W-1:0]      h_disp,
   input  logic [CNT_W-1:0]      v_disp,
   video_capture_if.master       wr_if
);

   // Registered sync/enable levels and their edges.
   logic vs_level_unused, vs_rise, vs_fall;
   logic de_level, de_rise_unused, de_fall;
   logic vs_start;

   vid_edge_det u_vs_det (
      .clk   (pixel_clk),
      .rst_n (sys_rst_n),
      .din   (vin_vs),
      .level (vs_level_unused),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   vid_edge_det u_de_det (
      .clk   (pixel_clk),
      .rst_n (sys_rst_n),
      .din   (vin_de),
      .level (de_level),
      .rise  (de_rise_unused),
      .fall  (de_fall)
   );

   // Frame start is the registered transition into the active vsync level.
   assign vs_start = VS_POL ? vs_rise : vs_fall;

   cap_state_e       state_q, state_d;
   logic [23:0]      rgb_q, rgb_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             wr_load_q, wr_load_d;
   logic             wr_en_q, wr_en_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic [CNT_W-1:0] xpos_q, xpos_d;
   logic [CNT_W-1:0] ypos_q, ypos_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Capture FSM and counters. The error flag is cleared the cycle after a
   // wr_load pulse, so at a frame boundary frame_err still shows the finished
   // frame's verdict alongside frame_done, and the new frame starts clean.
   always_comb begin
      state_d      = state_q;
      rgb_d        = vin_rgb;
      x_d          = x_q;
      y_d          = y_q;
      wr_load_d    = 1'b0;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      frame_done_d = 1'b0;
      frame_err_d  = wr_load_q ? 1'b0 : frame_err_q;

      if (!cap_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_VS;
            end

            // Anything seen before the first frame start is discarded.
            ST_WAIT_VS: begin
               if (vs_start) begin
                  state_d   = ST_ACTIVE;
                  wr_load_d = 1'b1;
                  x_d       = '0;
                  y_d       = '0;
               end
            end

            ST_ACTIVE: begin
               if (vs_start) begin
                  // Close this frame and open the next in the same cycle.
                  frame_done_d = 1'b1;
                  if (y_q != v_disp) begin
                     frame_err_d = 1'b1;
                  end
                  wr_load_d = 1'b1;
                  x_d       = '0;
                  y_d       = '0;
               end else if (de_level) begin
                  if ((x_q < h_disp) && (y_q < v_disp)) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = rgb888_to_565(rgb_q);
                     xpos_d    = x_q;
                     ypos_d    = y_q;
                  end
                  x_d = sat_inc(x_q);
               end else if (de_fall) begin
                  if (x_q != h_disp) begin
                     frame_err_d = 1'b1;
                  end
                  x_d = '0;
                  y_d = sat_inc(y_q);
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         rgb_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         wr_load_q    <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         xpos_q       <= '0;
         ypos_q       <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rgb_q        <= rgb_d;
         x_q          <= x_d;
         y_q          <= y_d;
         wr_load_q    <= wr_load_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign wr_if.wr_load    = wr_load_q;
   assign wr_if.wr_en      = wr_en_q;
   assign wr_if.wr_data    = wr_data_q;
   assign wr_if.pixel_xpos = xpos_q;
   assign wr_if.pixel_ypos = ypos_q;
   assign wr_if.frame_done = frame_done_q;
   assign wr_if.frame_err  = frame_err_q;

endmodule

// File: tb/tb_video_capture.sv
// ---------------------------------------------------------------------------
// tb_video_capture
// Directed bench for video_capture. Stimulus tasks queue the expected pixel
// writes; an independent monitor pops and compares every wr_en cycle and
// tallies frame_done / wr_load events for the per-scenario checks.
// ---------------------------------------------------------------------------
module tb_video_capture;

   localparam int CW = 11;

   logic           pixel_clk = 1'b0;
   logic           sys_rst_n;
   logic           cap_en;
   logic           vin_vs;
   logic           vin_de;
   logic [23:0]    vin_rgb;
   logic [CW-1:0]  h_disp;
   logic [CW-1:0]  v_disp;

   video_capture_if #(.CNT_W(CW)) wr_if ();

   video_capture #(.VS_POL(1'b1), .CNT_W(CW)) dut (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .cap_en    (cap_en),
      .vin_vs    (vin_vs),
      .vin_de    (vin_de),
      .vin_rgb   (vin_rgb),
      .h_disp    (h_disp),
      .v_disp    (v_disp),
      .wr_if     (wr_if)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [15:0]   d;
   } pix_t;

   pix_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   wrCount     = 0;
   int   doneCount   = 0;
   int   loadCount   = 0;
   int   bothCount   = 0;
   logic lastErr     = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: samples 1ns after each rising edge.
   initial begin
      pix_t e;
      forever begin
         @(posedge pixel_clk);
         #1;
         if (wr_if.wr_en === 1'b1) begin
            wrCount++;
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_write: got x=%0d y=%0d d=%0h, expected no write",
                        wr_if.pixel_xpos, wr_if.pixel_ypos, wr_if.wr_data);
            end else begin
               e = expQ.pop_front();
               checkOutput("pixel", 64'({wr_if.pixel_xpos, wr_if.pixel_ypos, wr_if.wr_data}),
                           64'(e));
            end
         end
         if (wr_if.frame_done === 1'b1) begin
            doneCount++;
            lastErr = wr_if.frame_err;
            if (wr_if.wr_load === 1'b1) bothCount++;
         end
         if (wr_if.wr_load === 1'b1) loadCount++;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500us;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] rgb);
      @(negedge pixel_clk);
      vin_vs  = vs;
      vin_de  = de;
      vin_rgb = rgb;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 24'h0);
   endtask

   task automatic vsPulse();
      applyStimulus(1'b1, 1'b0, 24'h0);
      applyStimulus(1'b1, 1'b0, 24'h0);
      idle(2);
   endtask

   function automatic logic [23:0] pat(input int line, input int p);
      return {8'(line * 37 + p * 29 + 5), 8'(p * 61 + line * 11 + 2), 8'(line * 83 + p * 7 + 200)};
   endfunction

   function automatic logic [15:0] to565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

   task automatic sendLine(input int line, input int npix, input bit wanted);
      for (int p = 0; p < npix; p++) begin
         logic [23:0] c;
         c = pat(line, p);
         applyStimulus(1'b0, 1'b1, c);
         if (wanted && p < int'(h_disp) && line < int'(v_disp))
            expQ.push_back(pix_t'{CW'(p), CW'(line), to565(c)});
      end
      idle(3);
   endtask

   task automatic sendFrame(input int nLines, input int npix, input bit wanted);
      for (int l = 0; l < nLines; l++) sendLine(l, npix, wanted);
   endtask

   task automatic stopCapture();
      @(negedge pixel_clk);
      cap_en = 1'b0;
      idle(3);
   endtask

   initial begin
      int d0, w0, l0, b0;

      sys_rst_n = 1'b0;
      cap_en    = 1'b0;
      vin_vs    = 1'b0;
      vin_de    = 1'b0;
      vin_rgb   = 24'h0;
      h_disp    = CW'(4);
      v_disp    = CW'(3);
      repeat (3) @(posedge pixel_clk);
      #1;
      checkOutput("rst_wr_en",      64'(wr_if.wr_en),      64'd0);
      checkOutput("rst_wr_load",    64'(wr_if.wr_load),    64'd0);
      checkOutput("rst_wr_data",    64'(wr_if.wr_data),    64'd0);
      checkOutput("rst_xpos",       64'(wr_if.pixel_xpos), 64'd0);
      checkOutput("rst_ypos",       64'(wr_if.pixel_ypos), 64'd0);
      checkOutput("rst_frame_done", 64'(wr_if.frame_done), 64'd0);
      checkOutput("rst_frame_err",  64'(wr_if.frame_err),  64'd0);
      @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      idle(2);

      // Clean 4x3 frame.
      $display("[TB] clean frame");
      d0 = doneCount; w0 = wrCount; l0 = loadCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      idle(4);
      checkOutput("clean_writes", 64'(wrCount - w0),   64'd12);
      checkOutput("clean_done",   64'(doneCount - d0), 64'd1);
      checkOutput("clean_loads",  64'(loadCount - l0), 64'd2);
      checkOutput("clean_err",    64'(lastErr),        64'd0);
      checkOutput("clean_qempty", 64'(expQ.size()),    64'd0);
      stopCapture();

      // Colour packing and two-cycle latency, 1x1 frame.
      $display("[TB] colour");
      h_disp = CW'(1);
      v_disp = CW'(1);
      d0 = doneCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      applyStimulus(1'b0, 1'b1, 24'hFF8040);
      expQ.push_back(pix_t'{CW'(0), CW'(0), 16'hFC08});
      @(posedge pixel_clk);
      applyStimulus(1'b0, 1'b0, 24'h0);
      @(posedge pixel_clk);
      #1;
      checkOutput("colour_wr_en",   64'(wr_if.wr_en),   64'd1);
      checkOutput("colour_wr_data", 64'(wr_if.wr_data), 64'hFC08);
      idle(3);
      vsPulse();
      idle(4);
      checkOutput("colour_done", 64'(doneCount - d0), 64'd1);
      checkOutput("colour_err",  64'(lastErr),        64'd0);
      stopCapture();

      // Oversize: 5 lines of 6 pixels into a 4x3 window.
      $display("[TB] oversize");
      h_disp = CW'(4);
      v_disp = CW'(3);
      d0 = doneCount; w0 = wrCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      sendFrame(5, 6, 1'b1);
      vsPulse();
      #1;
      checkOutput("over_err_cleared", 64'(wr_if.frame_err), 64'd0);
      idle(3);
      checkOutput("over_writes", 64'(wrCount - w0),   64'd12);
      checkOutput("over_done",   64'(doneCount - d0), 64'd1);
      checkOutput("over_err",    64'(lastErr),        64'd1);
      stopCapture();

      // Enable raised mid-frame: rest of that frame discarded.
      $display("[TB] mid-frame enable");
      d0 = doneCount; w0 = wrCount;
      vsPulse();
      sendLine(0, 4, 1'b0);
      for (int p = 0; p < 4; p++) begin
         applyStimulus(1'b0, 1'b1, pat(1, p));
         if (p == 1) cap_en = 1'b1;
      end
      idle(3);
      sendLine(2, 4, 1'b0);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      idle(4);
      checkOutput("midEn_writes", 64'(wrCount - w0),   64'd12);
      checkOutput("midEn_done",   64'(doneCount - d0), 64'd1);
      checkOutput("midEn_qempty", 64'(expQ.size()),    64'd0);
      stopCapture();

      // Back-to-back frames.
      $display("[TB] back-to-back");
      d0 = doneCount; w0 = wrCount; b0 = bothCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      idle(4);
      checkOutput("b2b_writes", 64'(wrCount - w0),   64'd24);
      checkOutput("b2b_done",   64'(doneCount - d0), 64'd2);
      checkOutput("b2b_both",   64'(bothCount - b0), 64'd2);
      checkOutput("b2b_err",    64'(lastErr),        64'd0);
      stopCapture();

      // Zero-size window: no writes, frame_done still pulses.
      $display("[TB] zero h_disp");
      h_disp = CW'(0);
      d0 = doneCount; w0 = wrCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      idle(4);
      checkOutput("zero_writes", 64'(wrCount - w0),   64'd0);
      checkOutput("zero_done",   64'(doneCount - d0), 64'd1);
      stopCapture();

      // Reset at pixel 2 of line 1.
      $display("[TB] reset mid-line");
      h_disp = CW'(4);
      d0 = doneCount; w0 = wrCount;
      @(negedge pixel_clk); cap_en = 1'b1;
      idle(2);
      vsPulse();
      sendLine(0, 4, 1'b1);
      applyStimulus(1'b0, 1'b1, pat(1, 0));
      expQ.push_back(pix_t'{CW'(0), CW'(1), to565(pat(1, 0))});
      applyStimulus(1'b0, 1'b1, pat(1, 1));
      @(negedge pixel_clk);
      sys_rst_n = 1'b0;
      vin_de    = 1'b0;
      #1;
      checkOutput("rstMid_wr_en",   64'(wr_if.wr_en),      64'd0);
      checkOutput("rstMid_wr_data", 64'(wr_if.wr_data),    64'd0);
      checkOutput("rstMid_xpos",    64'(wr_if.pixel_xpos), 64'd0);
      checkOutput("rstMid_ypos",    64'(wr_if.pixel_ypos), 64'd0);
      checkOutput("rstMid_err",     64'(wr_if.frame_err),  64'd0);
      idle(3);
      @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      idle(2);
      checkOutput("rstMid_writes_before", 64'(wrCount - w0),   64'd5);
      checkOutput("rstMid_no_done",       64'(doneCount - d0), 64'd0);
      sendLine(0, 4, 1'b0);
      vsPulse();
      sendFrame(3, 4, 1'b1);
      vsPulse();
      idle(4);
      checkOutput("rstMid_writes_total", 64'(wrCount - w0),   64'd17);
      checkOutput("rstMid_done",         64'(doneCount - d0), 64'd1);
      stopCapture();

      idle(5);
      checkOutput("final_qempty", 64'(expQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
